key_gen_sequencer: RTL
======================

KEY_GEN_SEQUENCER -- requirements
Module: key_gen_sequencer

Interface
REQ-001 Parameter: WARMUP, 16, number of chaos-settle cycles between generator restart and key capture; legal range 1..255.
REQ-002 Parameter: TIMEOUT, 64, delivery-stall cycle limit; used only when KEYSEQ_DELIVER_TIMEOUT_EN is defined.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  4  level request vector, one bit per requester.
REQ-006 Port: req_r  in  128  per-requester r operand; requester i in bits [32i+31:32i].
REQ-007 Port: req_s  in  128  per-requester s operand; same slicing as req_r.
REQ-008 Port: p  in  32  shared log base.
REQ-009 Port: grant  out  4  one-hot, one-cycle acceptance pulse.
REQ-010 Port: core_r, core_s, core_p  out  32 each  operands driven to the key-generator core.
REQ-011 Port: core_reset  out  1  chaos-generator restart pulse.
REQ-012 Port: core_key1, core_key2  in  32 each  keys returned by the core.
REQ-013 Port: key1, key2  out  32 each  delivered keys.
REQ-014 Port: key_valid  out  1 ; key_ready  in  1  delivery handshake.
REQ-015 Port: key_id  out  2  index of the requester owning the delivered keys.
REQ-016 Port: busy  out  1  high whenever state is not IDLE.
REQ-017 Port: timeout_err  out  1  one-cycle stall-abort pulse; present only with KEYSEQ_DELIVER_TIMEOUT_EN.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, WARM and DELIVER; all outputs SHALL be registered.
REQ-019 In IDLE with req nonzero, the next edge SHALL select a requester round-robin, starting from (last granted + 1) mod 4, latch its r and s values and p into core_r, core_s and core_p, pulse its grant bit, set key_id, and enter LOAD.
REQ-020 LOAD SHALL last exactly one cycle with core_reset=1, then enter WARM with the warm-up counter at 0; core_reset SHALL be 0 in every other state.
REQ-021 WARM SHALL increment the counter each cycle; on the edge where the counter equals WARMUP-1, it SHALL capture core_key1 and core_key2 into key1 and key2, set key_valid=1, and enter DELIVER.
REQ-022 key_valid SHALL therefore rise exactly WARMUP+1 cycles after the grant pulse.
REQ-023 In DELIVER, key1, key2, key_id and key_valid SHALL remain stable until key_valid and key_ready are both high on an edge.
REQ-024 On that handshake edge, key_valid SHALL go to 0, key1 and key2 SHALL be zeroed, and the FSM SHALL enter IDLE.
REQ-025 The minimum service period SHALL be WARMUP+3 cycles, because one IDLE cycle always follows each delivery.
REQ-026 core_r, core_s and core_p SHALL hold the latched values from LOAD through DELIVER; req_r, req_s, p and req changes SHALL be ignored outside IDLE.
REQ-027 A request withdrawn before its grant SHALL be dropped silently; a requester granted with req still high SHALL be lowest priority in the next arbitration.
REQ-028 key_ready while key_valid=0 SHALL have no effect.

Reset
REQ-029 On reset assertion, regardless of state, the FSM SHALL enter IDLE immediately and set every output to 0, including key_valid, key1, key2, grant and core_reset.
REQ-030 On reset, the round-robin pointer SHALL be set so that requester 0 has highest priority, and all counters SHALL be set to 0.
REQ-031 After reset deasserts, the first arbitration SHALL occur on the first edge with req nonzero.

Configuration
REQ-032 With KEYSEQ_DELIVER_TIMEOUT_EN defined, DELIVER SHALL count cycles with key_valid=1 and key_ready=0.
REQ-033 When that count reaches TIMEOUT, the block SHALL drop key_valid, zero key1 and key2, pulse timeout_err for one cycle, and enter IDLE.
REQ-034 A handshake on the same edge as the timeout SHALL take priority, and timeout_err SHALL stay 0.
REQ-035 Without KEYSEQ_DELIVER_TIMEOUT_EN, DELIVER SHALL wait indefinitely, and neither the timeout_err port nor the TIMEOUT logic SHALL exist.

Verification
REQ-036 Single request, WARMUP=4: req=4'b0010, key_ready=1 -> grant=4'b0010 for one cycle, core_reset=1 the next cycle, key_valid rises 5 cycles after grant with key_id=1 and key1/key2 equal to core_key1/core_key2, then drops after 1 cycle.
REQ-037 Fairness: req=4'b1111 held, key_ready=1 -> grants in order 0,1,2,3,0, each separated by WARMUP+3 cycles.
REQ-038 Backpressure: key_ready=0 for 10 cycles in DELIVER -> key1, key2 and key_id stable and key_valid held; key_ready=1 -> handshake, key1=key2=0 and busy=0 on the next cycle.
REQ-039 Reset in WARM: assert reset at WARM count 2 -> all outputs 0 immediately; the next req=4'b1000 is granted to requester 3, and req=4'b1001 is granted to requester 0.
REQ-040 With KEYSEQ_DELIVER_TIMEOUT_EN and TIMEOUT=8: key_ready held 0 -> key_valid drops after 8 stall cycles with one timeout_err pulse; key_ready=1 on cycle 8 -> handshake and no timeout_err.

Source files
------------

// File: rtl/key_gen_sequencer.sv
// key_gen_sequencer: round-robin front end for a chaos-based key-generator core.
// Picks one of four requesters, loads its operands into the core, restarts the
// chaotic generator, lets it settle for WARMUP cycles, captures the two keys and
// holds them on a valid/ready delivery port until they are taken.
// Optional feature macro: KEYSEQ_DELIVER_TIMEOUT_EN adds a TIMEOUT parameter, a
// stall counter in DELIVER and the timeout_err pulse output.
module key_gen_sequencer #(
  parameter int WARMUP = 16
`ifdef KEYSEQ_DELIVER_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] req_r,
  input  logic [127:0] req_s,
  input  logic [31:0]  p,
  output logic [3:0]   grant,
  output logic [31:0]  core_r,
  output logic [31:0]  core_s,
  output logic [31:0]  core_p,
  output logic         core_reset,
  input  logic [31:0]  core_key1,
  input  logic [31:0]  core_key2,
  output logic [31:0]  key1,
  output logic [31:0]  key2,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [1:0]   key_id,
`ifdef KEYSEQ_DELIVER_TIMEOUT_EN
  output logic         timeout_err,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WARM, S_DELIVER} state_t;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_cnt, w_cnt_nx;
  logic [1:0]  r_last, w_last_nx;
  logic [1:0]  w_pick;
  logic        w_found;
  logic [3:0]  w_grant_nx;
  logic [31:0] w_core_r_nx, w_core_s_nx, w_core_p_nx;
  logic        w_core_reset_nx;
  logic [31:0] w_key1_nx, w_key2_nx;
  logic        w_key_valid_nx;
  logic [1:0]  w_key_id_nx;

`ifdef KEYSEQ_DELIVER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] r_stall, w_stall_nx;
  logic               w_timeout_err_nx;
`endif

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_pick  = r_last;
    idx     = r_last;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last + 2'(k);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_last_nx       = r_last;
    w_grant_nx      = 4'b0000;
    w_core_r_nx     = core_r;
    w_core_s_nx     = core_s;
    w_core_p_nx     = core_p;
    w_core_reset_nx = 1'b0;
    w_key1_nx       = key1;
    w_key2_nx       = key2;
    w_key_valid_nx  = key_valid;
    w_key_id_nx     = key_id;
`ifdef KEYSEQ_DELIVER_TIMEOUT_EN
    w_stall_nx       = r_stall;
    w_timeout_err_nx = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nx  = 4'b0001 << w_pick;
          w_core_r_nx = req_r[32*w_pick +: 32];
          w_core_s_nx = req_s[32*w_pick +: 32];
          w_core_p_nx = p;
          w_key_id_nx = w_pick;
          w_last_nx   = w_pick;
          w_state_nx  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_core_reset_nx = 1'b1;
        w_cnt_nx        = 8'd0;
        w_state_nx      = S_WARM;
      end
      S_WARM: begin
        if (r_cnt == 8'(WARMUP - 1)) begin
          w_key1_nx      = core_key1;
          w_key2_nx      = core_key2;
          w_key_valid_nx = 1'b1;
          w_cnt_nx       = 8'd0;
          w_state_nx     = S_DELIVER;
`ifdef KEYSEQ_DELIVER_TIMEOUT_EN
          w_stall_nx     = '0;
`endif
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_DELIVER: begin
        // A handshake always wins over a timeout on the same edge.
        if (key_valid && key_ready) begin
          w_key_valid_nx = 1'b0;
          w_key1_nx      = 32'd0;
          w_key2_nx      = 32'd0;
          w_state_nx     = S_IDLE;
        end
`ifdef KEYSEQ_DELIVER_TIMEOUT_EN
        else if (r_stall == STALL_W'(TIMEOUT - 1)) begin
          w_key_valid_nx   = 1'b0;
          w_key1_nx        = 32'd0;
          w_key2_nx        = 32'd0;
          w_timeout_err_nx = 1'b1;
          w_stall_nx       = '0;
          w_state_nx       = S_IDLE;
        end else begin
          w_stall_nx = r_stall + 1'b1;
        end
`endif
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State and output registers; reset clears every output and favours requester 0.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_last     <= 2'd3;
      grant      <= 4'b0000;
      core_r     <= 32'd0;
      core_s     <= 32'd0;
      core_p     <= 32'd0;
      core_reset <= 1'b0;
      key1       <= 32'd0;
      key2       <= 32'd0;
      key_valid  <= 1'b0;
      key_id     <= 2'd0;
      busy       <= 1'b0;
`ifdef KEYSEQ_DELIVER_TIMEOUT_EN
      r_stall     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_last     <= w_last_nx;
      grant      <= w_grant_nx;
      core_r     <= w_core_r_nx;
      core_s     <= w_core_s_nx;
      core_p     <= w_core_p_nx;
      core_reset <= w_core_reset_nx;
      key1       <= w_key1_nx;
      key2       <= w_key2_nx;
      key_valid  <= w_key_valid_nx;
      key_id     <= w_key_id_nx;
      busy       <= (w_state_nx != S_IDLE);
`ifdef KEYSEQ_DELIVER_TIMEOUT_EN
      r_stall     <= w_stall_nx;
      timeout_err <= w_timeout_err_nx;
`endif
    end
  end

endmodule
